// File: rtl/jk_pkg.sv
// Shared definitions for the JK counter bank: mode encodings, JK cell op codes
// and the toggle-enable chain helper used by the up/down count decoders.
// Ports: none (package only).
package jk_pkg;

   localparam logic [1:0] MODE_JK = 2'b00;
   localparam logic [1:0] MODE_UP = 2'b01;
   localparam logic [1:0] MODE_DN = 2'b10;
   localparam logic [1:0] MODE_LD = 2'b11;

   // {J,K} pair as seen by one cell.
   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_CLR  = 2'b01,
      JK_SET  = 2'b10,
      JK_TGL  = 2'b11
   } jk_op_e;

   // Widest bank the helper supports; vectors are zero-extended to this.
   localparam int JK_MAX_W = 32;

   // Bit i of a ripple counter toggles iff bits i-1..0 of v are all 1.
   // Up count passes q, down count passes ~q (borrow chain).
   function automatic logic tgl_en(input logic [JK_MAX_W-1:0] v, input int i);
      logic run;
      run = 1'b1;
      for (int b = 0; b < JK_MAX_W; b++) begin
         if (b < i) run = run & v[b];
      end
      return run;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop bit: hold / clear / set / toggle on each rising clk edge.
// Ports: clk, rst (sync, active-high, forces q=0), j, k in; q, qbar out.
// Latency 1 clock; no backpressure (cell always accepts its J/K drive).
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qbar
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      case (jk_op_e'({j, k}))
         JK_HOLD: q_d = q_q;
         JK_CLR:  q_d = 1'b0;
         JK_SET:  q_d = 1'b1;
         JK_TGL:  q_d = ~q_q;
         default: q_d = q_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) q_q <= 1'b0;
      else     q_q <= q_d;
   end

   assign q    = q_q;
   assign qbar = ~q_q;

endmodule

// File: rtl/jk_counter_bank.sv
// WIDTH-bit register of JK cells with raw JK, modulo up, down and load modes.
// Ports: clk, rst (sync high), en, mode[1:0], j/k/d[WIDTH] in; q, qbar, tc out.
// Latency 1 clock in every mode; en=0 holds all cells, no other stall.
module jk_counter_bank
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2**WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc
);

   // Terminal value, compared on WIDTH+1 bits so MODULUS=2**WIDTH still fits.
   localparam logic [WIDTH:0] MAX_CNT = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH-1:0]    j_int;
   logic [WIDTH-1:0]    k_int;
   logic [WIDTH:0]      q_ext;
   logic                at_max;   // q >= MODULUS-1 (covers out-of-range q)
   logic                above_max;
   logic                is_zero;
   logic [JK_MAX_W-1:0] chain_in;
   logic [WIDTH-1:0]    tgl;

   assign q_ext     = {1'b0, q};
   assign at_max    = (q_ext >= MAX_CNT);
   assign above_max = (q_ext > MAX_CNT);
   assign is_zero   = (q == '0);

   // Toggle-enable chain: carry chain for up, borrow chain (on ~q) for down.
   always_comb begin
      chain_in = '0;
      chain_in[WIDTH-1:0] = (mode == MODE_DN) ? ~q : q;
      tgl = '0;
      for (int i = 0; i < WIDTH; i++) begin
         tgl[i] = tgl_en(chain_in, i);
      end
   end

   // Mode decoder: every mode is expressed as per-bit J/K drive.
   always_comb begin
      j_int = '0;
      k_int = '0;
      if (en) begin
         case (mode)
            MODE_JK: begin
               j_int = j;
               k_int = k;
            end
            MODE_UP: begin
               if (at_max) begin
                  j_int = '0;
                  k_int = '1;
               end else begin
                  j_int = tgl;
                  k_int = tgl;
               end
            end
            MODE_DN: begin
               // Wrap (or out-of-range recovery) lands on MODULUS-1.
               if (is_zero || above_max) begin
                  j_int = MAX_CNT[WIDTH-1:0];
                  k_int = ~MAX_CNT[WIDTH-1:0];
               end else begin
                  j_int = tgl;
                  k_int = tgl;
               end
            end
            MODE_LD: begin
               j_int = d;
               k_int = ~d;
            end
            default: begin
               j_int = '0;
               k_int = '0;
            end
         endcase
      end
   end

   assign tc = en & (((mode == MODE_UP) & at_max) | ((mode == MODE_DN) & is_zero));

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
         .clk  (clk),
         .rst  (rst),
         .j    (j_int[g]),
         .k    (k_int[g]),
         .q    (q[g]),
         .qbar (qbar[g])
      );
   end

endmodule
